// File: rtl/stim_check.sv
// Stimulus generator and response checker: sweeps a 4-bit pattern into four
// variants of the same logic function and scores each response against a model.
module stim_check #(
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a0,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  input  logic             z1,
  input  logic             z2,
  input  logic             z3,
  input  logic             z4,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           r_state;
  logic [3:0]       r_a;
  logic [3:0]       r_h1;
  logic [3:0]       r_h2;
  logic             r_v1;
  logic             r_v2;
  logic             r_drain;
  logic             r_busy;
  logic             r_done;
  logic [ERR_W-1:0] r_err;
  logic [3:0]       r_mask;

  logic             w_active;
  logic [3:0]       w_mis;
  logic [2:0]       w_nmis;
  logic [ERR_W-1:0] w_err_next;

  function automatic logic f_fn(input logic [3:0] p);
    return (p[0] | ~p[1]) & (p[2] | p[3]);
  endfunction

  function automatic logic g_fn(input logic [3:0] p);
    return f_fn(p) ^ p[0];
  endfunction

  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc,
                                               input logic [2:0]       inc);
    logic [ERR_W+2:0] s;
    logic [ERR_W+2:0] lim;
    s   = (ERR_W+3)'(acc) + (ERR_W+3)'(inc);
    lim = (ERR_W+3)'({ERR_W{1'b1}});
    return (s > lim) ? {ERR_W{1'b1}} : s[ERR_W-1:0];
  endfunction

  // Case-inequality so an X/Z response is scored as a mismatch
  always_comb begin
    w_active = (r_state == RUN) || (r_state == DRAIN);
    w_mis    = 4'b0000;
    w_mis[0] = (r_state == RUN) && (z1 !== g_fn(r_a));
    w_mis[1] = (r_state == RUN) && (z2 !== g_fn(r_a));
    w_mis[2] = w_active && r_v1 && (z3 !== g_fn(r_h1));
    w_mis[3] = w_active && r_v2 && (z4 !== (f_fn(r_h2) ^ r_h1[0]));
    w_nmis   = {2'b00, w_mis[0]} + {2'b00, w_mis[1]}
             + {2'b00, w_mis[2]} + {2'b00, w_mis[3]};
    w_err_next = sat_add(r_err, w_nmis);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= 4'h0;
      r_h1    <= 4'h0;
      r_h2    <= 4'h0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_drain <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
      r_mask  <= 4'b0000;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            r_a     <= 4'h0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_drain <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= '0;
            r_mask  <= 4'b0000;
          end
        end
        RUN, DRAIN: begin
          r_err  <= w_err_next;
          r_mask <= r_mask | w_mis;
          r_h1   <= r_a;
          r_h2   <= r_h1;
          r_v1   <= 1'b1;
          r_v2   <= r_v1;
          if (r_state == RUN) begin
            if (r_a == 4'hF) begin
              r_state <= DRAIN;
              r_drain <= 1'b0;
            end else begin
              r_a <= r_a + 4'd1;
            end
          end else if (r_drain) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {a3, a2, a1, a0} = r_a;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err;
  assign fail_mask = r_mask;
  assign pass      = r_done && (r_err == '0);

endmodule

// File: tb/tb_stim_check.sv
// Directed bench for stim_check: a behavioural model of the four DUT variants
// with selectable faults, driven through a table of full runs plus corner sequences.
module tb_stim_check;
  localparam int ERR_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             a0, a1, a2, a3;
  logic             z1, z2, z3, z4;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_mask;

  logic             b_a0, b_a1, b_a2, b_a3;
  logic             b_busy, b_done, b_pass;
  logic [1:0]       b_err;
  logic [3:0]       b_mask;

  int mode;
  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stim_check #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask)
  );

  // Second instance: narrow counter, every response stuck at 1
  stim_check #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start),
    .a0(b_a0), .a1(b_a1), .a2(b_a2), .a3(b_a3),
    .z1(1'b1), .z2(1'b1), .z3(1'b1), .z4(1'b1),
    .busy(b_busy), .done(b_done), .pass(b_pass),
    .err_count(b_err), .fail_mask(b_mask)
  );

  function automatic logic mf(input logic [3:0] p);
    return (p[0] | ~p[1]) & (p[2] | p[3]);
  endfunction
  function automatic logic mg(input logic [3:0] p);
    return mf(p) ^ p[0];
  endfunction

  logic [3:0] a_vec;
  logic       g_now, z3_m, q1_m, z4_m;
  assign a_vec = {a3, a2, a1, a0};
  assign g_now = mg(a_vec);

  always_ff @(posedge clk) begin
    z3_m <= mg(a_vec);
    q1_m <= mf(a_vec);
    z4_m <= q1_m ^ a_vec[0];
  end

  // mode: 0 clean, 1 z1 stuck0, 2 z3 wired to z1, 3 z2 stuck1, 4 z4 inverted, 5 z3 inverted
  assign z1 = (mode == 1) ? 1'b0 : g_now;
  assign z2 = (mode == 3) ? 1'b1 : g_now;
  assign z3 = (mode == 2) ? g_now : ((mode == 5) ? ~z3_m : z3_m);
  assign z4 = (mode == 4) ? ~z4_m : z4_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic do_run(input int m, input int hold, output int nbusy, output bit aok);
    int guard;
    logic [3:0] expa;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    nbusy = 0;
    aok   = 1'b1;
    guard = 0;
    while (!done && guard < 40) begin
      if (nbusy + 1 >= hold) start = 1'b0;
      if (busy) begin
        expa = (nbusy < 16) ? 4'(nbusy) : 4'hF;
        if (a_vec !== expa) aok = 1'b0;
        nbusy++;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("run_timeout", {31'd0, done}, 32'd1);
  endtask

  typedef struct {
    int         m;
    logic [4:0] exp_err;
    logic [3:0] exp_mask;
    logic       exp_pass;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  nb;
    bit  aok;
    vecs[0] = '{0, 5'd0,  4'b0000, 1'b1};
    vecs[1] = '{1, 5'd5,  4'b0001, 1'b0};
    vecs[2] = '{2, 5'd8,  4'b0100, 1'b0};
    vecs[3] = '{3, 5'd11, 4'b0010, 1'b0};
    vecs[4] = '{4, 5'd16, 4'b1000, 1'b0};
    vecs[5] = '{5, 5'd17, 4'b0100, 1'b0};

    rst = 1'b1; start = 1'b0; mode = 0;
    repeat (2) @(negedge clk);
    chk("rst_a",    {28'd0, a_vec}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_err",  {27'd0, err_count}, 32'd0);
    chk("rst_mask", {28'd0, fail_mask}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_run(vecs[i].m, 1, nb, aok);
      chk($sformatf("v%0d_busy_len", i), nb, 32'd18);
      chk($sformatf("v%0d_a_seq", i), {31'd0, aok}, 32'd1);
      chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
      chk($sformatf("v%0d_err", i), {27'd0, err_count}, {27'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_mask", i), {28'd0, fail_mask}, {28'd0, vecs[i].exp_mask});
      chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, vecs[i].exp_pass});
      chk($sformatf("v%0d_sat_err", i), {30'd0, b_err}, 32'd3);
      chk($sformatf("v%0d_sat_mask", i), {28'd0, b_mask}, 32'hF);
    end

    repeat (3) @(negedge clk);
    chk("hold_a",    {28'd0, a_vec}, 32'hF);
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_err",  {27'd0, err_count}, 32'd17);
    chk("hold_mask", {28'd0, fail_mask}, 32'b0100);

    // Abort at run cycle 7 with z1 faulted, then a clean run
    @(negedge clk);
    mode = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_a",    {28'd0, a_vec}, 32'd7);
    chk("mid_err",  {27'd0, err_count}, 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("abort_a",    {28'd0, a_vec}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_err",  {27'd0, err_count}, 32'd0);
    chk("abort_mask", {28'd0, fail_mask}, 32'd0);
    chk("abort_done", {31'd0, done | pass}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    do_run(0, 1, nb, aok);
    chk("clean_len",  nb, 32'd18);
    chk("clean_pass", {31'd0, pass}, 32'd1);
    chk("clean_err",  {27'd0, err_count}, 32'd0);

    // start held through RUN, then a restart from DONE
    do_run(1, 17, nb, aok);
    chk("held_len",  nb, 32'd18);
    chk("held_aseq", {31'd0, aok}, 32'd1);
    chk("held_err",  {27'd0, err_count}, 32'd5);
    @(negedge clk);
    mode = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_a",    {28'd0, a_vec}, 32'd0);
    chk("restart_err",  {27'd0, err_count}, 32'd0);
    chk("restart_mask", {28'd0, fail_mask}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    chk("restart_done", {31'd0, done}, 32'd0);
    wait_done();
    chk("restart_pass", {31'd0, pass}, 32'd1);
    chk("restart_fin_mask", {28'd0, fail_mask}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/stim_check.md
STIM_CHECK -- requirements
Module: stim_check

Interface
REQ-001 The block SHALL have parameter ERR_W, default 5, giving the width of the error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: launches one test run when sampled high in IDLE or DONE.
REQ-005 The block SHALL have ports a0, a1, a2, a3, each output, 1 bit: registered stimulus to the device under test (DUT).
REQ-006 The block SHALL have port z1, input, 1 bit: response from the continuous-assignment variant, with 0-cycle latency.
REQ-007 The block SHALL have port z2, input, 1 bit: response from the always_comb variant, with 0-cycle latency.
REQ-008 The block SHALL have port z3, input, 1 bit: response from the clocked variant that uses blocking assignments, with 1-cycle latency.
REQ-009 The block SHALL have port z4, input, 1 bit: response from the clocked variant that uses non-blocking assignments, which is two-stage.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-011 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-012 The block SHALL have port pass, output, 1 bit: equal to done AND (err_count == 0).
REQ-013 The block SHALL have port err_count, output, ERR_W bits: total mismatches, saturating.
REQ-014 The block SHALL have port fail_mask, output, 4 bits: sticky per-response failure flags; bit k covers z(k+1).

Function
REQ-015 Pattern notation: p(i) is the 4-bit value {a3,a2,a1,a0} driven during run cycle i. Cycle 0 is the first cycle after start is accepted.
REQ-016 Helper functions: f(p) = (p[0] | ~p[1]) & (p[2] | p[3]), and g(p) = f(p) ^ p[0].
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN and DONE; reset state is IDLE.
REQ-018 IDLE -> RUN on start; DONE -> RUN on start; in RUN and DRAIN start SHALL be ignored.
REQ-019 On entering RUN, the block SHALL clear err_count and fail_mask, and a[3:0] SHALL take 4'h0 at the same edge.
REQ-020 In RUN, a[3:0] SHALL increment by 1 each cycle: p(i) = i for i = 0..15.
REQ-021 After p = 4'hF has been driven, the FSM SHALL go RUN -> DRAIN; DRAIN SHALL last exactly 2 cycles (cycles 16 and 17) with a held at 4'hF.
REQ-022 After the second DRAIN cycle the FSM SHALL go DRAIN -> DONE; done rises at the 18th rising edge after the edge that accepted start.
REQ-023 The block SHALL keep a history of the last two applied patterns, p(i-1) and p(i-2), each with a valid bit cleared on entering RUN.
REQ-024 Each check SHALL sample the z input at the rising edge that ends cycle i.
REQ-025 z1 and z2 SHALL be checked in cycles 0..15, with expected value g(p(i)).
REQ-026 z3 SHALL be checked in cycles 1..17, with expected value g(p(i-1)).
REQ-027 z4 SHALL be checked in cycles 2..17, with expected value f(p(i-2)) ^ p(i-1)[0].
REQ-028 Each check SHALL be skipped whenever its required history entry is not valid; no check SHALL occur in IDLE or DONE.
REQ-029 Per cycle, err_count SHALL increase by the number of mismatching checks (0..4), saturating at 2^ERR_W-1.
REQ-030 On a mismatch of z(k+1), fail_mask[k] SHALL be set; it stays set until the next accepted start or reset.
REQ-031 In DONE, a SHALL hold at 4'hF and err_count, fail_mask and pass SHALL be stable.
REQ-032 A z input that is X or Z SHALL count as a mismatch (case-inequality compare).

Reset
REQ-033 While rst is high, the block SHALL be in IDLE, and a0..a3, busy, done, pass, err_count and fail_mask SHALL all be 0.
REQ-034 Reset asserted mid-run SHALL abort immediately to IDLE and clear the history valid bits, with no partial result retained.
REQ-035 The first start is accepted at the first rising edge on which rst is low and start is high.

Verification
REQ-036 Correct 4-variant top connected, start pulsed for 1 cycle -> busy high for 18 cycles, then done=1, pass=1, err_count=0, fail_mask=4'b0000.
REQ-037 z1 forced stuck-at-0, others correct -> err_count=5 (g=1 for p in {4,8,12,1,3}... i.e. 5 patterns), fail_mask=4'b0001, pass=0.
REQ-038 z3 wired to z1 (latency error) -> fail_mask[2]=1, fail_mask[1:0]=0, pass=0.
REQ-039 All z tied to 1 with ERR_W=2 -> err_count saturates at 3, fail_mask=4'b1111.
REQ-040 rst pulsed at run cycle 7 -> all outputs 0 in IDLE; a following start gives a full clean run with pass=1.
REQ-041 start held high through RUN, then start pulsed again in DONE -> no restart during RUN; a second full run starts from p=0, with counters cleared at the restart edge.
